mel_filterbank_seq: RTL and testbench

Initiator side of the mel coefficient lookup interface: walks all mel filters for one frame and drives `mel_idx`/`coeff_idx` into the combinational coefficient table. Reads the matching power-spectrum bins from the frame buffer and multiply-accumulates weight × power. Emits one mel energy per filter on a valid/ready stream. Sits between the power-spectrum buffer (FFT |X|² output) and the log stage.

---
 rtl/mel_pkg.sv | 21 ++
 rtl/mel_mac.sv | 35 +++
 rtl/mel_filterbank_seq.sv | 118 +++++++++++
 tb/tb_mel_filterbank_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mel_pkg.sv
// rtl/mel_pkg.sv - shared parameters and sequencer state type for the mel filterbank
package mel_pkg;
  localparam int MEL_BINS   = 40;
  localparam int MAX_COEFFS = 12;
  localparam int COEFF_W    = 16;
  localparam int BIN_W      = 7;
  localparam int PWR_W      = 32;
  localparam int ACC_W      = 52;

  localparam int MEL_IDX_W = $clog2(MEL_BINS);
  localparam int CIDX_W    = $clog2(MAX_COEFFS);
  localparam int PROD_W    = PWR_W + COEFF_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUT,
    S_FIN
  } melfb_state_t;
endpackage

// File: rtl/mel_mac.sv
// rtl/mel_mac.sv - weight pipe register and weight x power accumulator
module mel_mac
  import mel_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               rd_en,
  input  logic [COEFF_W-1:0] weight_in,
  input  logic [PWR_W-1:0]   spec_data,
  output logic [ACC_W-1:0]   acc
);
  logic [COEFF_W-1:0] w_pipe;
  logic               rd_d1;
  logic [PROD_W-1:0]  prod;

  // Weight is held one cycle so it lines up with the buffer's read latency.
  assign prod = {{PWR_W{1'b0}}, w_pipe} * {{COEFF_W{1'b0}}, spec_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_pipe <= '0;
      rd_d1  <= 1'b0;
      acc    <= '0;
    end else begin
      rd_d1 <= rd_en;
      if (rd_en)
        w_pipe <= weight_in;
      if (clear)
        acc <= '0;
      else if (rd_d1)
        acc <= acc + {{(ACC_W-PROD_W){1'b0}}, prod};
    end
  end
endmodule

// File: rtl/mel_filterbank_seq.sv
// rtl/mel_filterbank_seq.sv - walks all mel filters per frame and streams one energy per filter
// Optional stall_cnt output when MELFB_STALL_CNT_EN is defined.
module mel_filterbank_seq
  import mel_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [MEL_IDX_W-1:0] mel_idx,
  output logic [CIDX_W-1:0]    coeff_idx,
  input  logic [COEFF_W-1:0]   weight_in,
  input  logic [BIN_W-1:0]     start_bin_in,
  input  logic [BIN_W-1:0]     end_bin_in,
  output logic                 spec_rd_en,
  output logic [BIN_W-1:0]     spec_addr,
  input  logic [PWR_W-1:0]     spec_data,
  output logic                 mel_valid,
  input  logic                 mel_ready,
  output logic [ACC_W-1:0]     mel_data,
  output logic [MEL_IDX_W-1:0] mel_num
`ifdef MELFB_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);
  localparam logic [BIN_W:0] SPAN_MAX = (BIN_W+1)'(MAX_COEFFS);

  melfb_state_t         state, state_nxt;
  logic [MEL_IDX_W-1:0] m;
  logic [CIDX_W-1:0]    k, n;
  logic [BIN_W:0]       span;
  logic                 start_acc, out_hs, last_mel, last_issue, rd_en;
  logic [ACC_W-1:0]     acc;

  // Weight count for the current filter; inverted ranges mean an empty filter.
  assign span = {1'b0, end_bin_in} - {1'b0, start_bin_in} + (BIN_W+1)'(1);

  always_comb begin
    n = '0;
    if (end_bin_in < start_bin_in)
      n = '0;
    else if (span > SPAN_MAX)
      n = CIDX_W'(MAX_COEFFS);
    else
      n = span[CIDX_W-1:0];
  end

  assign start_acc  = (state == S_IDLE) && start;
  assign out_hs     = (state == S_OUT) && mel_ready;
  assign last_mel   = (m == MEL_IDX_W'(MEL_BINS - 1));
  assign rd_en      = (state == S_ISSUE) && (k < n);
  assign last_issue = (n == '0) || (k == n - CIDX_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      m     <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc || state == S_FIN)
        m <= '0;
      else if (out_hs && !last_mel)
        m <= m + 1'b1;
      if (start_acc || out_hs)
        k <= '0;
      else if (rd_en)
        k <= k + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_OUT;
      S_OUT:   if (mel_ready) state_nxt = last_mel ? S_FIN : S_ISSUE;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == S_ISSUE) || (state == S_DRAIN) || (state == S_OUT);
    done       = (state == S_FIN);
    mel_valid  = (state == S_OUT);
    mel_data   = (state == S_OUT) ? acc : '0;
    mel_num    = m;
    mel_idx    = m;
    spec_rd_en = rd_en;
    coeff_idx  = rd_en ? k : '0;
    spec_addr  = rd_en ? (start_bin_in + BIN_W'(k)) : '0;
  end

  mel_mac u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_acc || out_hs),
    .rd_en     (rd_en),
    .weight_in (weight_in),
    .spec_data (spec_data),
    .acc       (acc)
  );

`ifdef MELFB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (start_acc)
      stall_cnt <= '0;
    else if (mel_valid && !mel_ready && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_mel_filterbank_seq.sv
// tb/tb_mel_filterbank_seq.sv - scoreboard bench for mel_filterbank_seq with table and spectrum models
module tb_mel_filterbank_seq;
  import mel_pkg::*;

  logic                 clk, rst_n, start, busy, done;
  logic [MEL_IDX_W-1:0] mel_idx, mel_num;
  logic [CIDX_W-1:0]    coeff_idx;
  logic [COEFF_W-1:0]   weight_in;
  logic [BIN_W-1:0]     start_bin_in, end_bin_in, spec_addr;
  logic                 spec_rd_en, mel_valid, mel_ready;
  logic [PWR_W-1:0]     spec_data;
  logic [ACC_W-1:0]     mel_data;
`ifdef MELFB_STALL_CNT_EN
  logic [31:0]          stall_cnt;
`endif

  typedef struct {
    longint unsigned data;
    int              num;
    int              reads;
  } exp_t;

  exp_t              sb[$];
  logic [PWR_W-1:0]  spec_mem [0:127];
  int                tests = 0;
  int                fails = 0;
  int                rd_cnt = 0;
  bit                exp_done = 0;

  mel_filterbank_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .mel_idx      (mel_idx),
    .coeff_idx    (coeff_idx),
    .weight_in    (weight_in),
    .start_bin_in (start_bin_in),
    .end_bin_in   (end_bin_in),
    .spec_rd_en   (spec_rd_en),
    .spec_addr    (spec_addr),
    .spec_data    (spec_data),
    .mel_valid    (mel_valid),
    .mel_ready    (mel_ready),
    .mel_data     (mel_data),
    .mel_num      (mel_num)
`ifdef MELFB_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Filter layout: 0 = bins 2..4 at 0.5, 1 = empty, 2 = 20-bin span clamped to 12.
  function automatic int f_start(int m);
    if (m == 0) return 2;
    if (m == 1) return 10;
    if (m == 2) return 5;
    return 3 * m - 6;
  endfunction

  function automatic int f_end(int m);
    if (m == 0) return 4;
    if (m == 1) return 5;
    if (m == 2) return 24;
    return f_start(m) + (m % 7);
  endfunction

  function automatic int f_weight(int m, int k);
    if (m == 0) return 32'h8000;
    return (m * 257 + k * 13 + 1) & 16'hFFFF;
  endfunction

  function automatic int f_n(int m);
    int s, e;
    s = f_start(m);
    e = f_end(m);
    if (e < s) return 0;
    return (e - s + 1 > MAX_COEFFS) ? MAX_COEFFS : e - s + 1;
  endfunction

  always_comb begin
    start_bin_in = BIN_W'(f_start(int'(mel_idx)));
    end_bin_in   = BIN_W'(f_end(int'(mel_idx)));
    weight_in    = COEFF_W'(f_weight(int'(mel_idx), int'(coeff_idx)));
  end

  always @(posedge clk)
    if (spec_rd_en) spec_data <= spec_mem[spec_addr];

  task automatic check(string name, longint unsigned act, longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int m = 0; m < MEL_BINS; m++) begin
      e.data  = 0;
      e.num   = m;
      e.reads = f_n(m);
      for (int k = 0; k < f_n(m); k++)
        e.data += longint'(f_weight(m, k)) * longint'(spec_mem[f_start(m) + k]);
      sb.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ctrl"}, {busy, done, mel_valid, spec_rd_en}, 0);
    check({tag, "_mel_data"}, mel_data, 0);
    check({tag, "_mel_num"}, mel_num, 0);
    check({tag, "_mel_idx"}, mel_idx, 0);
    check({tag, "_coeff_idx"}, coeff_idx, 0);
    check({tag, "_spec_addr"}, spec_addr, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(string tag);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: done not seen within 3000 cycles", tag);
    end
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  // Monitor: pops on every accepted output, tracks read sequence and done timing.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rd_cnt   = 0;
      exp_done = 0;
    end else begin
      if (exp_done || done) check("done_pulse", done, exp_done);
      exp_done = 0;
      if (spec_rd_en) begin
        check("coeff_idx", coeff_idx, rd_cnt);
        check("spec_addr", spec_addr, (f_start(int'(mel_idx)) + rd_cnt) & 127);
        rd_cnt++;
      end
      if (mel_valid && mel_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: mel_num %0d with empty scoreboard", mel_num);
        end else begin
          e = sb.pop_front();
          check("mel_data", mel_data, e.data);
          check("mel_num", mel_num, e.num);
          check("read_count", rd_cnt, e.reads);
          if (e.num == MEL_BINS - 1) exp_done = 1;
        end
        rd_cnt = 0;
      end
    end
  end

  initial begin
    int lat;
    bit seen;
    logic [ACC_W-1:0]     hold_data;
    logic [MEL_IDX_W-1:0] hold_num;

    rst_n     = 1'b0;
    start     = 1'b0;
    mel_ready = 1'b1;
    for (int b = 0; b < 128; b++) spec_mem[b] = PWR_W'(b * 3 + 1);
    spec_mem[2] = 10;
    spec_mem[3] = 20;
    spec_mem[4] = 30;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
`ifdef MELFB_STALL_CNT_EN
    check("por_stall_cnt", stall_cnt, 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;

    // Frame 1: filter 0 hand value and first-output latency.
    push_frame();
    sb[0].data = 64'd1966080;
    sb[1].data = 64'd0;
    pulse_start();
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy_after_start", busy, 1);
      if (mel_valid) seen = 1;
    end
    check("first_latency", lat, 5);
    wait_done("frame1");
    @(negedge clk);
    check("busy_idle", busy, 0);

    // Frame 2: flat spectrum, stray start mid-frame must be ignored.
    for (int b = 0; b < 128; b++) spec_mem[b] = 1;
    push_frame();
    pulse_start();
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("frame2");

    // Frame 3: wide products and 7-cycle backpressure on filter 0.
    for (int b = 0; b < 128; b++) spec_mem[b] = 32'hF000_0000 + PWR_W'(b * 4099);
    push_frame();
    mel_ready = 1'b0;
    pulse_start();
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mel_valid) seen = 1;
    end
    check("stall_valid_seen", seen, 1);
    hold_data = mel_data;
    hold_num  = mel_num;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stall_data", mel_data, hold_data);
      check("stall_num", mel_num, hold_num);
      check("stall_valid", mel_valid, 1);
      check("stall_rd_en", spec_rd_en, 0);
    end
    @(posedge clk); #1 mel_ready = 1'b1;
    wait_done("frame3");
`ifdef MELFB_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 7);
`endif

    // Frame 4: reset during filter 5 reads, then a clean frame from filter 0.
    push_frame();
    pulse_start();
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (spec_rd_en && mel_idx == 5) seen = 1;
    end
    check("reached_filter5", seen, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    sb.delete();
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    check_reset_outputs("midreset_hold");
    @(posedge clk); #1 rst_n = 1'b1;

    for (int b = 0; b < 128; b++) spec_mem[b] = PWR_W'(1000 + b * 17);
    push_frame();
    pulse_start();
    wait_done("frame5");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
